// File: rtl/dm_copy_pkg.sv
// dm_copy_pkg -- shared definitions for the data-memory block-copy engine.
//   DM_ADDR_W : default word-address width (64 words)
//   DM_DATA_W : default data-memory word width
//   dm_state_e: copy FSM states
package dm_copy_pkg;

  localparam int DM_ADDR_W = 6;
  localparam int DM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dm_state_e;

endpackage

// File: rtl/dm_copy_engine.sv
// dm_copy_engine -- forward block-copy engine that owns the data-memory port.
// Each word takes two cycles: RD presents the source address, WR presents the
// destination address and writes back the word the memory returned for RD.
//
// Ports
//   clk_dm    : clock, all state changes on rising edge
//   rst       : asynchronous active-high reset
//   start     : copy request, only looked at in IDLE
//   src_addr  : first source word address (latched on start)
//   dst_addr  : first destination word address (latched on start)
//   len       : word count 0..2^ADDR_W (latched on start)
//   busy      : high while in RD or WR
//   done      : one-cycle completion pulse
//   Mem_Write : memory write enable
//   DM_Addr   : memory word address (byte address bits [7:2])
//   M_W_Data  : memory write data
//   M_R_Data  : memory read data, valid one cycle after DM_Addr
//   checksum  : (DM_COPY_CHECKSUM_EN only) running sum of copied words
//
// Build option
//   DM_COPY_CHECKSUM_EN : adds the checksum output and its accumulator.
module dm_copy_engine
  import dm_copy_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
) (
  input  logic                clk_dm,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  output logic                Mem_Write,
  output logic [ADDR_W+1:2]   DM_Addr,
  output logic [DATA_W-1:0]   M_W_Data,
  input  logic [DATA_W-1:0]   M_R_Data
`ifdef DM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  dm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_dm or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from state_q so an async reset drops Mem_Write
  // in the same cycle rst rises.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    done      = 1'b0;
    Mem_Write = 1'b0;
    DM_Addr   = '0;
    M_W_Data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = len;
          state_d = (len == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        busy    = 1'b1;
        DM_Addr = src_q;
        state_d = ST_WR;
      end
      ST_WR: begin
        busy      = 1'b1;
        Mem_Write = 1'b1;
        DM_Addr   = dst_q;
        M_W_Data  = M_R_Data;
        // Pointers wrap naturally at ADDR_W bits.
        src_d     = src_q + ADDR_W'(1);
        dst_d     = dst_q + ADDR_W'(1);
        cnt_d     = cnt_q - (ADDR_W+1)'(1);
        state_d   = (cnt_q > (ADDR_W+1)'(1)) ? ST_RD : ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_ff @(posedge clk_dm or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  // Cleared on an accepted start, accumulates each written word, and holds
  // its final value until the next start.
  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_IDLE && start) csum_d = '0;
    else if (state_q == ST_WR)       csum_d = csum_q + M_R_Data;
  end

  assign checksum = csum_q;
`endif

endmodule
